// File: rtl/fetch_stage.sv
// Instruction fetch stage: pc sequencing, delay-slot redirect and SRAM request.
// Optional FETCH_INSTRUCTION_BUFFER_EN holds the fetched word across decode stalls.
module fetch_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        id_allow_in,
    input  logic [32:0] id_to_if_branch_bus,
    output logic [64:0] if_to_id_instruction_bus,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_write_enabled,
    output logic [31:0] inst_sram_address,
    output logic [31:0] inst_sram_write_data,
    input  logic [31:0] inst_sram_read_data
);

    localparam logic [31:0] RESET_PC = 32'hBFBF_FFFC;
    localparam logic [31:0] BOOT_PC  = 32'hBFC0_0000;

    logic [31:0] pc;
    logic [31:0] pending_target;
    logic [31:0] next_pc;
    logic [31:0] target;
    logic [31:0] instruction;
    logic        if_valid;
    logic        branch_pending;
    logic        if_allow_in;
    logic        if_ready_go;
    logic        taken;

    assign {taken, target} = id_to_if_branch_bus;

    assign if_ready_go = 1'b1;
    assign if_allow_in = !if_valid || (if_ready_go && id_allow_in);

    // A latched redirect outranks a live one; a live one only counts
    // once the delay slot already sits in IF.
    always_comb begin
        next_pc = pc + 32'd4;
        if (branch_pending) begin
            next_pc = pending_target;
        end else if (taken && if_valid) begin
            next_pc = target;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc             <= RESET_PC;
            if_valid       <= 1'b0;
            branch_pending <= 1'b0;
            pending_target <= 32'h0;
        end else begin
            if (if_allow_in) begin
                pc       <= next_pc;
                if_valid <= 1'b1;
            end
            if (branch_pending) begin
                if (if_allow_in) begin
                    branch_pending <= 1'b0;
                end
            end else if (taken && !if_valid) begin
                branch_pending <= 1'b1;
                pending_target <= target;
            end
        end
    end

`ifdef FETCH_INSTRUCTION_BUFFER_EN
    logic [31:0] buffer;
    logic        buffer_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            buffer       <= 32'h0;
            buffer_valid <= 1'b0;
        end else if (id_allow_in) begin
            buffer_valid <= 1'b0;
        end else if (if_valid && !buffer_valid) begin
            buffer       <= inst_sram_read_data;
            buffer_valid <= 1'b1;
        end
    end

    assign instruction       = buffer_valid ? buffer : inst_sram_read_data;
    assign inst_sram_en      = !reset && if_allow_in;
    assign inst_sram_address = reset ? BOOT_PC : next_pc;
`else
    logic stall;

    // Without a buffer the held word is re-read from pc every stall cycle.
    assign stall             = if_valid && !id_allow_in;
    assign instruction       = inst_sram_read_data;
    assign inst_sram_en      = !reset && (if_allow_in || stall);
    assign inst_sram_address = reset ? BOOT_PC : (stall ? pc : next_pc);
`endif

    assign inst_sram_write_enabled  = 4'b0000;
    assign inst_sram_write_data     = 32'h0;
    assign if_to_id_instruction_bus = {if_valid, pc, instruction};

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have ports, in order: clock, reset, id_allow_in, id_to_if_branch_bus, if_to_id_instruction_bus, inst_sram_en, inst_sram_write_enabled, inst_sram_address, inst_sram_write_data, inst_sram_read_data.
REQ-002 clock  input  1  stage clock; all state updates on posedge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 id_allow_in  input  1  decode stage can accept an instruction this cycle.
REQ-005 id_to_if_branch_bus  input  33  {taken (1), target (32)}: decode-resolved redirect; taken is combinational and held while decode holds the branch.
REQ-006 if_to_id_instruction_bus  output  65  {valid (1), program_count (32), instruction (32)} to decode.
REQ-007 inst_sram_en  output  1  instruction SRAM read request.
REQ-008 inst_sram_write_enabled  output  4  byte write enables; constant 4'b0000.
REQ-009 inst_sram_address  output  32  fetch address (next_pc).
REQ-010 inst_sram_write_data  output  32  constant 32'h0.
REQ-011 inst_sram_read_data  input  32  read data, valid exactly one cycle after an accepted request.

Function
REQ-012 Internal state SHALL be: pc (32), if_valid (1), branch_pending (1), pending_target (32), plus instruction buffer per REQ-026.
REQ-013 if_allow_in SHALL equal !if_valid || id_allow_in; if_ready_go SHALL be constant 1; bus.valid SHALL equal if_valid.
REQ-014 Pre-fetch is valid every non-reset cycle; inst_sram_en SHALL equal !reset && if_allow_in.
REQ-015 next_pc priority: branch_pending ? pending_target : (taken && if_valid) ? target : pc + 4 (modulo 2^32, no overflow flag).
REQ-016 When if_allow_in: pc <= next_pc, if_valid <= 1 next cycle; otherwise pc and if_valid SHALL hold.
REQ-017 bus.program_count SHALL equal pc; bus.instruction per REQ-026.
REQ-018 Delay slot: taken with if_valid=1 means IF holds the delay slot; target is fetched on the first cycle if_allow_in=1 while taken is still asserted.
REQ-019 taken && !if_valid (delay slot not yet fetched): SHALL set branch_pending, latch pending_target <= target, fetch pc + 4 as the delay slot.
REQ-020 branch_pending SHALL clear on the first later cycle with if_allow_in=1 (that fetch uses pending_target); a taken arriving while branch_pending=1 SHALL be ignored.
REQ-021 Simultaneous taken and if_allow_in=0 with if_valid=1: no state change; redirect applied when allow-in rises.
REQ-022 Misaligned target (target[1:0] != 0) SHALL be fetched unmodified; no exception generated in this block.

Reset
REQ-023 While reset=1: pc <= 32'hBFBF_FFFC, if_valid <= 0, branch_pending <= 0, pending_target <= 0, buffer valid <= 0.
REQ-024 Output values during reset: bus.valid=0, inst_sram_en=0, inst_sram_address=32'hBFC0_0000, write enables 0; first fetch after reset deassertion SHALL be 32'hBFC0_0000.
REQ-025 Reset asserted mid-stall or mid-redirect SHALL discard pending branch and held instruction within one cycle.

Configuration
REQ-026 Macro FETCH_INSTRUCTION_BUFFER_EN: defined -> 32-bit buffer + valid bit capture inst_sram_read_data on the first cycle if_valid && !id_allow_in, bus.instruction = buffer valid ? buffer : read_data, buffer valid clears when id_allow_in=1, and inst_sram_en follows REQ-014; undefined -> no buffer, while if_valid && !id_allow_in inst_sram_en SHALL be 1 with inst_sram_address = pc (re-read each stall cycle), and bus.instruction = inst_sram_read_data.
REQ-027 Both builds SHALL produce identical bus sequences to decode.

Verification
REQ-028 Reset release, id_allow_in=1, SRAM returns addr -> requests BFC00000, BFC00004, BFC00008 in consecutive cycles; bus.valid rises one cycle after first request with pc BFC00000.
REQ-029 Branch at BFC00004 in decode, taken=1 target=BFC00100, IF holding BFC00008 -> next request BFC00100; bus sequence BFC00008 then BFC00100.
REQ-030 id_allow_in=0 for 3 cycles with IF holding pc BFC00010 -> pc, bus held stable, instruction unchanged; with macro undefined inst_sram_address=BFC00010 each stall cycle.
REQ-031 taken=1 target=80000000 while if_valid=0, pc=BFC00020 -> fetch BFC00024 then 80000000; branch_pending 1 for exactly one cycle.
REQ-032 Stall with taken held 2 cycles then id_allow_in=1 -> exactly one fetch of target, no duplicate delay slot.
REQ-033 reset pulsed during stall with branch_pending=1 -> bus.valid=0 next cycle, next fetch BFC00000.
